// File: rtl/opl3_host_pkg.sv
// Shared types and defaults for the OPL3 host write path.
package opl3_host_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ASSERT_FILT  = 2'd1,
    ACTIVE       = 2'd2,
    RELEASE_FILT = 2'd3
  } host_fsm_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } host_write_t;

endpackage

// File: rtl/host_write_fifo.sv
// First-word-fall-through FIFO for captured host writes. A push into a full
// FIFO is still accepted when a pop happens in the same cycle; otherwise it is
// dropped and reported on drop.
module host_write_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers may move in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; cleared by synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/host_write_sequencer.sv
// Brings asynchronous host writes onto the synth clock: synchronizes the
// strobe and bus, glitch-filters the strobe on both edges, captures the bus
// while the strobe is held, and queues one entry per genuine write.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for the synchronized strobe to assert
// ASSERT_FILT  | strobe asserted, counting consecutive high cycles
// ACTIVE       | genuine write in progress, bus sampled every cycle
// RELEASE_FILT | strobe released, counting consecutive low cycles
module host_write_sequencer
  import opl3_host_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int FILTER_CYCLES = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n_async,
  input  logic                  wr_n_async,
  input  logic [ADDR_WIDTH-1:0] addr_async,
  input  logic [DATA_WIDTH-1:0] data_async,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                  strobe_raw;
  logic                  strobe_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] data_s;

  host_fsm_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  push_q;

  logic                  fifo_empty;
  logic                  fifo_drop;
  logic                  fifo_pop;

  assign strobe_raw = ~cs_n_async & ~wr_n_async;

  sync_2ff #(.WIDTH(1)) u_sync_strobe (
    .clk   (clk),
    .reset (reset),
    .d     (strobe_raw),
    .q     (strobe_s)
  );

  sync_2ff #(.WIDTH(ADDR_WIDTH)) u_sync_addr (
    .clk   (clk),
    .reset (reset),
    .d     (addr_async),
    .q     (addr_s)
  );

  sync_2ff #(.WIDTH(DATA_WIDTH)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (data_async),
    .q     (data_s)
  );

  // Strobe filter FSM; the push strobe is registered so the FIFO sees it one
  // cycle after the release filter completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      push_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe_s) begin
            if (FILTER_CYCLES == 1) begin
              state <= ACTIVE;
              cnt   <= '0;
            end else begin
              state <= ASSERT_FILT;
              cnt   <= CNT_ONE;
            end
          end
        end
        ASSERT_FILT: begin
          if (!strobe_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ACTIVE: begin
          cap_addr <= addr_s;
          cap_data <= data_s;
          if (!strobe_s) begin
            if (FILTER_CYCLES == 1) begin
              state  <= IDLE;
              cnt    <= '0;
              push_q <= 1'b1;
            end else begin
              state <= RELEASE_FILT;
              cnt   <= CNT_ONE;
            end
          end
        end
        RELEASE_FILT: begin
          if (strobe_s) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            push_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign fifo_pop = out_valid & out_ready;

  host_write_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   ({cap_addr, cap_data}),
    .pop   (fifo_pop),
    .dout  ({out_addr, out_data}),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign out_valid = ~fifo_empty;
  assign busy      = (state != IDLE) | ~fifo_empty;

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/host_write_sequencer.md
Name: host_write_sequencer

Overview:
Sequences asynchronous host (MCU/CPU) writes into the OPL3 register-write path on the synth clock.
- Brings the host strobe and bus in through two-stage synchronizer instances.
- Glitch-filters the strobe, captures address/data once per genuine write, and queues each write in a small FIFO.
- Presents queued writes to the register-file writer with a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, host data bus width
ADDR_WIDTH, 2, host address bus width (A1:A0 bank/port select)
FILTER_CYCLES, 3, consecutive synchronized-strobe cycles required to accept an assert or a release (>=1)
FIFO_DEPTH, 4, queued writes (power of two, >=2)

Ports:
clk  in  1  synth clock
reset  in  1  synchronous active-high reset
cs_n_async  in  1  host chip select, active low, asynchronous
wr_n_async  in  1  host write strobe, active low, asynchronous
addr_async  in  ADDR_WIDTH  host address, asynchronous
data_async  in  DATA_WIDTH  host data, asynchronous
out_valid  out  1  FIFO head holds a write
out_ready  in  1  consumer accepts head this cycle
out_addr  out  ADDR_WIDTH  head address
out_data  out  DATA_WIDTH  head data
overflow  out  1  sticky: a write was dropped because the FIFO was full
overflow_clr  in  1  clears overflow
busy  out  1  FSM not IDLE, or FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Synchronization:
  - strobe_raw = ~cs_n_async & ~wr_n_async.
  - strobe_raw, addr_async and data_async each pass through a two-flop synchronizer.
  - The synchronized values are strobe_s, addr_s and data_s, each 2 cycles behind its input.
- Reset:
  - FSM goes to IDLE; filter counter = 0; FIFO emptied.
  - out_valid = 0, overflow = 0, busy = 0.
  - out_addr/out_data = 0 while empty.
  - Synchronizer flops are also cleared to 0.
- FSM states and transitions:
  - IDLE: strobe_s=1 -> ASSERT_FILT with cnt=1. If FILTER_CYCLES==1, go straight to ACTIVE instead.
  - ASSERT_FILT:
    - strobe_s=1: cnt++. When cnt reaches FILTER_CYCLES -> ACTIVE.
    - strobe_s=0: -> IDLE, cnt=0, nothing captured (glitch rejected).
  - ACTIVE: every cycle latch cap_addr<=addr_s and cap_data<=data_s. strobe_s=0 -> RELEASE_FILT with cnt=1.
  - RELEASE_FILT:
    - strobe_s=0: cnt++. When cnt reaches FILTER_CYCLES -> push {cap_addr, cap_data} and go to IDLE.
    - strobe_s=1: -> ACTIVE (release glitch ignored, no push).
    - No capture happens in this state, so the pushed value is the last value sampled while ACTIVE.
- Latency:
  - The push is registered on the cycle the release filter completes.
  - out_valid rises on the next cycle when the FIFO was empty.
  - Host strobe release to out_valid = 2 + FILTER_CYCLES + 1 cycles.
- FIFO: first-word-fall-through.
  - out_valid = !empty; out_addr/out_data = head.
  - Pop happens when out_valid & out_ready.
  - Push and pop in the same cycle are both performed, including when full: the pop frees the slot and the push is accepted.
  - Push when full with no pop: write dropped, overflow<=1, FIFO unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
- Overflow register:
  - Set has priority over overflow_clr in the same cycle.
  - Otherwise overflow_clr=1 clears it.
- Reset in any state aborts the in-progress write; queued entries are lost.
- out_ready with out_valid=0 has no effect.

Decomposition:
- Shared package (opl3_host_pkg):
  - typedef host_write_t {addr, data}.
  - FSM state enum {IDLE, ASSERT_FILT, ACTIVE, RELEASE_FILT}.
  - Default DATA_WIDTH/ADDR_WIDTH constants.
- Sub-modules:
  - Existing synchronizer module, instanced per signal group.
  - One natural new sub-module: host_write_fifo (FWFT, parameterized depth, full/empty, simultaneous push/pop).

Test Plan:
- Single write: FILTER_CYCLES=3, host drives addr=2'b01, data=8'hA5, holds strobe 10 cycles, then releases.
  -> out_valid rises exactly 6 cycles after release; head = {01, A5}; with out_ready=1 it pops in one cycle; busy returns to 0.
- Glitch reject: strobe low pulse of 2 cycles (below FILTER_CYCLES=3).
  -> no push, out_valid stays 0, FSM returns to IDLE.
- Release glitch: during ACTIVE, strobe released for 2 cycles then reasserted, then a real release with data=8'h3C.
  -> exactly one entry, data 3C.
- Overflow: out_ready=0, 5 writes with data 01..05, FIFO_DEPTH=4.
  -> entries 01..04 queued, 05 dropped, overflow=1.
  -> Drain yields 01,02,03,04.
  -> overflow_clr clears the flag, but not on a cycle where a new drop occurs.
- Full push+pop: FIFO full, out_ready=1 on the cycle a new write (data=8'h77) pushes.
  -> no overflow; 77 becomes the tail; count stays 4.
- Reset mid-operation: assert reset while in RELEASE_FILT with 2 entries queued.
  -> next cycle out_valid=0, busy=0, overflow=0; no push follows.
